crc_frame_serializer: RTL
=========================

Name: crc_frame_serializer

Overview:
- Upstream feeder and result collector for the serial CRC-8 generator stage.
- Accepts a frame of FRAME_BYTES bytes over a valid/ready byte interface and serializes each byte onto a 1-bit data line while holding the generator's ACTIVE high.
- After the frame it drops ACTIVE and collects the 8 serial CRC bits the generator shifts out under its valid strobe, assembling them into a parallel byte.
- Detects data underrun, readout timeout and truncated readout, and flags each as an error.

Parameters:
- FRAME_BYTES, 4: bytes per frame, legal range 1..255.
- CRC_WIDTH, 8: number of CRC bits to capture.
- TIMEOUT, 15: maximum cycles in WAIT_CRC before crc_valid_in must rise.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- in_data  input  8  byte to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  byte accepted when in_valid&in_ready at a rising edge.
- data_out  output  1  serial bit to the CRC generator's Data input.
- active_out  output  1  to the CRC generator's ACTIVE input.
- crc_in  input  1  serial CRC bit from the generator.
- crc_valid_in  input  1  generator's valid strobe.
- crc_out  output  CRC_WIDTH  captured CRC; bit i = i-th received bit.
- crc_done  output  1  one-cycle pulse when crc_out is updated.
- err  output  1  one-cycle pulse on underrun, timeout or truncated readout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: data_out=0, active_out=0, crc_out=0, crc_done=0, err=0, busy=0; state=IDLE, so in_ready=1 immediately after reset release.
- data_out, active_out, crc_out, crc_done and err are registered. in_ready is combinational from state and counters.
- States: IDLE, SHIFT, WAIT_CRC, CAPTURE.
- IDLE:
  - in_ready=1.
  - On accept: load the shift register, byte_cnt=0, bit_cnt=0, go to SHIFT.
  - From the next cycle: active_out=1 and data_out=in_data[0] (LSB first).
- SHIFT:
  - Each cycle emits one bit; bit_cnt increments from 0 to 7.
  - in_ready=1 only when bit_cnt==7 and byte_cnt<FRAME_BYTES-1.
  - If the next byte is accepted on that cycle, it is loaded with no gap: active_out stays high and bit0 of the new byte follows bit7 of the previous byte in consecutive cycles.
  - Underrun: bit_cnt==7, byte_cnt<FRAME_BYTES-1 and in_valid=0. The next cycle gives active_out=0 and err=1 pulse, and the state returns to IDLE. The frame is aborted and no crc_done is produced.
  - Last bit of the last byte: the next cycle gives active_out=0 and data_out=0; go to WAIT_CRC with wait counter=0.
- WAIT_CRC:
  - active_out=0.
  - crc_valid_in=1: capture crc_in into crc_out[0], cap_cnt=1, go to CAPTURE.
  - Otherwise the wait counter increments. When it reaches TIMEOUT: err pulse, go to IDLE.
  - Nominal generator response: crc_valid_in rises one cycle after active_out falls.
- CAPTURE:
  - crc_valid_in=1: crc_out[cap_cnt]<=crc_in and cap_cnt increments.
  - After bit CRC_WIDTH-1 is captured: crc_done pulses in the following cycle with the full crc_out stable, then go to IDLE.
  - crc_valid_in=0 before CRC_WIDTH bits: err pulse, go to IDLE. crc_out keeps its partial contents and crc_done is not asserted.
- crc_out holds its value until the next capture starts. Only bits being written change.
- in_valid while busy and in_ready=0 is ignored, and the byte is not consumed.
- Reset asserted mid-frame: all state and outputs return to their reset values immediately (asynchronous). active_out falls with no err pulse.
- Counter widths: byte_cnt 8 bits, bit_cnt 3 bits, cap_cnt and wait counter sized by $clog2 of CRC_WIDTH+1 and TIMEOUT+1.

Optional Feature:
- Macro: SER_MSB_FIRST_EN.
- Defined: each byte is serialized MSB first (in_data[7] first); capture order is unchanged.
- Undefined: LSB first as described above.

Test Plan:
- Single frame: FRAME_BYTES=1, accept 0xA5.
  - active_out high exactly 8 cycles with data_out=1,0,1,0,0,1,0,1.
  - Stub returns valid one cycle later with bits 1,0,1,1,0,0,0,1; expect crc_out=0x8D and one crc_done pulse.
- Back-to-back frame: FRAME_BYTES=4, in_valid held high with 0x01,0x02,0x04,0x08.
  - active_out high for 32 contiguous cycles.
  - in_ready high only in IDLE and at bit 7 of bytes 0-2.
- Underrun: FRAME_BYTES=2, second byte withheld.
  - active_out falls after 8 bits, err pulses once, returns to IDLE, no crc_done.
- Timeout: stub never raises crc_valid_in.
  - err pulses exactly TIMEOUT cycles after entering WAIT_CRC; state returns to IDLE; in_ready=1.
- Truncated readout: stub valid high for 5 cycles only.
  - err pulse, no crc_done, crc_out[4:0] updated.
- Reset mid-SHIFT at bit 3: outputs return to their reset values immediately; a new 0x3C frame afterwards completes normally.

Source files
------------

// File: rtl/crc_frame_serializer.sv
// Feeds a frame bit-serially to the CRC-8 generator and collects its serial CRC into a byte.
// Optional SER_MSB_FIRST_EN: serialize each byte MSB first (capture order is unchanged).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for the first byte of a frame, in_ready high
// SHIFT    | driving frame bits on data_out with active_out high
// WAIT_CRC | frame sent, waiting (bounded) for the generator's valid strobe
// CAPTURE  | shifting the serial CRC bits into crc_out
module crc_frame_serializer #(
    parameter int FRAME_BYTES = 4,
    parameter int CRC_WIDTH   = 8,
    parameter int TIMEOUT     = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 data_out,
    output logic                 active_out,
    input  logic                 crc_in,
    input  logic                 crc_valid_in,
    output logic [CRC_WIDTH-1:0] crc_out,
    output logic                 crc_done,
    output logic                 err,
    output logic                 busy
);
    localparam int CAP_W  = $clog2(CRC_WIDTH + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [7:0]        LAST_BYTE = 8'(FRAME_BYTES - 1);
    localparam logic [CAP_W-1:0]  LAST_CAP  = CAP_W'(CRC_WIDTH - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CRC,
        CAPTURE
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            shreg, shreg_nxt;
    logic [7:0]            byte_cnt, byte_nxt;
    logic [2:0]            bit_cnt, bit_nxt;
    logic [CAP_W-1:0]      cap_cnt, cap_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
    logic                  data_nxt;
    logic                  active_nxt;
    logic [CRC_WIDTH-1:0]  crc_nxt;
    logic                  done_nxt;
    logic                  err_nxt;

    logic [2:0] bit_idx;
    logic [2:0] sel_idx;
    logic       load_bit;

    // The byte is held intact; the bit to emit is selected by bit position.
    assign bit_idx = bit_cnt + 3'd1;
`ifdef SER_MSB_FIRST_EN
    assign sel_idx  = 3'd7 - bit_idx;
    assign load_bit = in_data[7];
`else
    assign sel_idx  = bit_idx;
    assign load_bit = in_data[0];
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shreg      <= '0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            cap_cnt    <= '0;
            wait_cnt   <= '0;
            data_out   <= 1'b0;
            active_out <= 1'b0;
            crc_out    <= '0;
            crc_done   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            byte_cnt   <= byte_nxt;
            bit_cnt    <= bit_nxt;
            cap_cnt    <= cap_nxt;
            wait_cnt   <= wait_nxt;
            data_out   <= data_nxt;
            active_out <= active_nxt;
            crc_out    <= crc_nxt;
            crc_done   <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        byte_nxt   = byte_cnt;
        bit_nxt    = bit_cnt;
        cap_nxt    = cap_cnt;
        wait_nxt   = wait_cnt;
        data_nxt   = data_out;
        active_nxt = active_out;
        crc_nxt    = crc_out;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        in_ready   = 1'b0;

        case (state)
            IDLE: begin
                in_ready   = 1'b1;
                data_nxt   = 1'b0;
                active_nxt = 1'b0;
                if (in_valid) begin
                    shreg_nxt  = in_data;
                    byte_nxt   = 8'd0;
                    bit_nxt    = 3'd0;
                    data_nxt   = load_bit;
                    active_nxt = 1'b1;
                    state_nxt  = SHIFT;
                end
            end

            SHIFT: begin
                active_nxt = 1'b1;
                if (bit_cnt != 3'd7) begin
                    bit_nxt  = bit_idx;
                    data_nxt = shreg[sel_idx];
                end else if (byte_cnt < LAST_BYTE) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        // Next byte follows with no gap in the serial stream.
                        shreg_nxt = in_data;
                        byte_nxt  = byte_cnt + 8'd1;
                        bit_nxt   = 3'd0;
                        data_nxt  = load_bit;
                    end else begin
                        active_nxt = 1'b0;
                        data_nxt   = 1'b0;
                        err_nxt    = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else begin
                    active_nxt = 1'b0;
                    data_nxt   = 1'b0;
                    wait_nxt   = '0;
                    state_nxt  = WAIT_CRC;
                end
            end

            WAIT_CRC: begin
                active_nxt = 1'b0;
                data_nxt   = 1'b0;
                if (crc_valid_in) begin
                    crc_nxt[0] = crc_in;
                    cap_nxt    = CAP_W'(1);
                    if (CRC_WIDTH == 1) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = CAPTURE;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end

            CAPTURE: begin
                if (crc_valid_in) begin
                    for (int i = 0; i < CRC_WIDTH; i++) begin
                        if (cap_cnt == CAP_W'(i)) crc_nxt[i] = crc_in;
                    end
                    cap_nxt = cap_cnt + 1'b1;
                    if (cap_cnt == LAST_CAP) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    // Strobe dropped early: keep the partial CRC, flag it.
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
